// File: rtl/i2s_rx16.sv
// rtl/i2s_rx16.sv - I2S slave receiver, 16-bit words, one-bit I2S delay
//
// Purpose:
//   Recovers 16-bit I2S words from external BSCK/LCRK/RXD pins in the CLK
//   domain. Each completed word is presented with its channel tag and a
//   one-cycle rx_valid strobe; slots of illegal length give rx_err instead.
//
// Optional feature macro: I2S_RX_PAIR_EN
//   When defined, left/right words are paired and presented on
//   pair_left/pair_right with a pair_valid strobe.
//
// Ports:
//   CLK        in   system clock
//   RST_n      in   asynchronous active-low reset
//   BSCK       in   external bit clock (asynchronous to CLK)
//   LCRK       in   external word select, 0 = left, 1 = right
//   RXD        in   serial data, changes on falling BSCK
//   rx_data    out  last completed word
//   rx_right   out  channel of rx_data
//   rx_valid   out  one-CLK strobe, rx_data/rx_right updated
//   rx_err     out  one-CLK strobe, slot length illegal, word dropped
//   pair_left  out  (I2S_RX_PAIR_EN) left word of last pair
//   pair_right out  (I2S_RX_PAIR_EN) right word of last pair
//   pair_valid out  (I2S_RX_PAIR_EN) one-CLK strobe, pair updated

module i2s_rx16 #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SLOT_MAX    = 32
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              BSCK,
  input  logic              LCRK,
  input  logic              RXD,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_right,
  output logic              rx_valid,
  output logic              rx_err
`ifdef I2S_RX_PAIR_EN
  ,
  output logic [DATA_W-1:0] pair_left,
  output logic [DATA_W-1:0] pair_right,
  output logic              pair_valid
`endif
);

  // Counter must reach SLOT_MAX+1 so an over-long slot stays distinguishable.
  localparam int CNT_W = $clog2(SLOT_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_MAX + 1);

  // ST_IDLE : nothing seen since reset; the first rise only learns LCRK.
  // ST_SYNC : LCRK level known, waiting for the first slot boundary.
  // ST_RUN  : a slot started at a seen boundary; its close may be emitted.
  // Priming on the first rise keeps a slot that was cut by reset from being
  // judged at the next boundary, so nothing is reported for it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] bsck_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] rxd_sync;
  logic                   bsck_dly;

  logic                   rise;
  logic                   lr;
  logic                   d;

  logic [CNT_W-1:0]       bit_cnt, cnt_nxt;
  logic [DATA_W-1:0]      shift_reg, shift_nxt;
  logic                   lr_prev, lr_prev_nxt;
  logic                   close_ok;
  logic                   close_bad;

  // Identical chains keep the three pins mutually aligned after
  // synchronisation. bsck_dly is reset high with the chain so a pin that is
  // already high at reset release is not mistaken for a rise.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      bsck_sync <= '1;
      lrck_sync <= '1;
      rxd_sync  <= '0;
      bsck_dly  <= 1'b1;
    end else begin
      bsck_sync <= {bsck_sync[SYNC_STAGES-2:0], BSCK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], LCRK};
      rxd_sync  <= {rxd_sync[SYNC_STAGES-2:0], RXD};
      bsck_dly  <= bsck_sync[SYNC_STAGES-1];
    end
  end

  assign rise = bsck_sync[SYNC_STAGES-1] & ~bsck_dly;
  assign lr   = lrck_sync[SYNC_STAGES-1];
  assign d    = rxd_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      lr_prev   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      shift_reg <= shift_nxt;
      lr_prev   <= lr_prev_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bit_cnt;
    shift_nxt   = shift_reg;
    lr_prev_nxt = lr_prev;
    close_ok    = 1'b0;
    close_bad   = 1'b0;
    if (rise) begin
      if (state == ST_IDLE) begin
        lr_prev_nxt = lr;
        cnt_nxt     = '0;
        state_nxt   = ST_SYNC;
      end else if (lr != lr_prev) begin
        // Slot boundary: judge the slot that just ended. bit_cnt excludes the
        // delay bit, so slot length = bit_cnt + 1.
        if (state == ST_RUN) begin
          if ((bit_cnt >= CNT_DATA) && (bit_cnt <= CNT_MAX)) begin
            close_ok = 1'b1;
          end else begin
            close_bad = 1'b1;
          end
        end
        // This rise carries the delay bit; its data is discarded.
        cnt_nxt     = '0;
        lr_prev_nxt = lr;
        state_nxt   = ST_RUN;
      end else begin
        if (bit_cnt != CNT_SAT) begin
          cnt_nxt = bit_cnt + CNT_ONE;
        end
        // Only the first DATA_W bits after the delay bit are kept; padding
        // bits beyond them leave the word untouched.
        if ((cnt_nxt >= CNT_ONE) && (cnt_nxt <= CNT_DATA)) begin
          shift_nxt = {shift_reg[DATA_W-2:0], d};
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rx_data  <= '0;
      rx_right <= 1'b0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= close_ok;
      rx_err   <= close_bad;
      if (close_ok) begin
        rx_data  <= shift_reg;
        rx_right <= lr_prev;
      end
    end
  end

`ifdef I2S_RX_PAIR_EN
  logic              held_valid;
  logic [DATA_W-1:0] held_left;

  // A left word waits here for its right partner. Anything that breaks the
  // left-then-right order (an error, or a right word with nothing held)
  // discards the waiting word.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      held_valid <= 1'b0;
      held_left  <= '0;
      pair_left  <= '0;
      pair_right <= '0;
      pair_valid <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      if (close_ok) begin
        if (!lr_prev) begin
          held_left  <= shift_reg;
          held_valid <= 1'b1;
        end else begin
          if (held_valid) begin
            pair_left  <= held_left;
            pair_right <= shift_reg;
            pair_valid <= 1'b1;
          end
          held_valid <= 1'b0;
        end
      end else if (close_bad) begin
        held_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx16.sv
// tb/tb_i2s_rx16.sv - scoreboard bench for i2s_rx16 driven by a slot-level I2S BFM

module tb_i2s_rx16;

  localparam int DATA_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int SLOT_MAX    = 32;

  logic        CLK   = 1'b0;
  logic        RST_n = 1'b0;
  logic        BSCK  = 1'b0;
  logic        LCRK  = 1'b0;
  logic        RXD   = 1'b0;
  logic [15:0] rx_data;
  logic        rx_right;
  logic        rx_valid;
  logic        rx_err;
`ifdef I2S_RX_PAIR_EN
  logic [15:0] pair_left;
  logic [15:0] pair_right;
  logic        pair_valid;
`endif

  i2s_rx16 #(
    .DATA_W(DATA_W),
    .SYNC_STAGES(SYNC_STAGES),
    .SLOT_MAX(SLOT_MAX)
  ) dut (
    .CLK(CLK),
    .RST_n(RST_n),
    .BSCK(BSCK),
    .LCRK(LCRK),
    .RXD(RXD),
    .rx_data(rx_data),
    .rx_right(rx_right),
    .rx_valid(rx_valid),
    .rx_err(rx_err)
`ifdef I2S_RX_PAIR_EN
    ,
    .pair_left(pair_left),
    .pair_right(pair_right),
    .pair_valid(pair_valid)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    bit          ch;
    logic [15:0] data;
    logic [15:0] hold;
    bit          pair;
    logic [15:0] pl;
    logic [15:0] pr;
    int          at;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int passes = 0;

  // Slot-level reference model state
  int          s         = 0;
  bit          last_ch   = 1'b1;
  int          prev_len  = 0;
  bit          prev_ch   = 1'b0;
  logic [15:0] prev_data = '0;
  logic [15:0] last_data = '0;
  bit          held      = 1'b0;
  logic [15:0] held_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected outcome of closing the previous slot: legal if it carried at
  // least DATA_W and at most SLOT_MAX bits after the delay bit.
  task automatic push_close(input int at);
    exp_t e;
    e.at   = at;
    e.hold = last_data;
    e.ch   = prev_ch;
    e.data = prev_data;
    e.pair = 1'b0;
    e.pl   = '0;
    e.pr   = '0;
    if ((prev_len - 1 >= DATA_W) && (prev_len - 1 <= SLOT_MAX)) begin
      e.is_err  = 1'b0;
      last_data = prev_data;
      if (!prev_ch) begin
        held      = 1'b1;
        held_data = prev_data;
      end else begin
        if (held) begin
          e.pair = 1'b1;
          e.pl   = held_data;
          e.pr   = prev_data;
        end
        held = 1'b0;
      end
    end else begin
      e.is_err = 1'b1;
      held     = 1'b0;
    end
    q.push_back(e);
  endtask

  task automatic do_reset_pulse();
    @(posedge CLK);
    #2 RST_n = 1'b0;
    #1;
    chk("rst_data", rx_data, 0);
    chk("rst_right", rx_right, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_err", rx_err, 0);
`ifdef I2S_RX_PAIR_EN
    chk("rst_pair_valid", pair_valid, 0);
    chk("rst_pair_left", pair_left, 0);
`endif
    repeat (3) @(posedge CLK);
    #2 RST_n = 1'b1;
    s         = 1;
    held      = 1'b0;
    last_data = '0;
  endtask

  // One slot of len BSCK periods (4 CLK low, 4 CLK high). LCRK and RXD change
  // on the falling edge; rise 0 carries the delay bit, rises 1..16 the word.
  // rst_after >= 0 pulses reset in the low phase after that rise.
  task automatic send_slot(input logic [15:0] data, input int len, input int rst_after);
    bit ch;
    ch      = ~last_ch;
    last_ch = ch;
    s++;
    for (int i = 0; i < len; i++) begin
      BSCK = 1'b0;
      if (i == 0) LCRK = ch;
      RXD = (i >= 1 && i <= 16) ? data[16-i] : 1'b0;
      if (rst_after >= 0 && i == rst_after + 1) do_reset_pulse();
      repeat (4) @(posedge CLK);
      #1;
      BSCK = 1'b1;
      if (i == 0 && s >= 3) push_close(cyc + 1 + SYNC_STAGES);
      repeat (4) @(posedge CLK);
      #1;
    end
    prev_len  = len;
    prev_ch   = ch;
    prev_data = data;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST_n) begin
      if (rx_valid || rx_err) begin
        chk("strobe_exclusive", {31'd0, rx_valid & rx_err}, 0);
        chk("strobe_expected", {31'd0, q.size() > 0}, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("latency", cyc, e.at);
          chk("kind_err", {31'd0, rx_err}, {31'd0, e.is_err});
          if (e.is_err) begin
            chk("err_hold_data", rx_data, e.hold);
`ifdef I2S_RX_PAIR_EN
            chk("err_no_pair", pair_valid, 0);
`endif
          end else begin
            chk("data", rx_data, e.data);
            chk("right", rx_right, e.ch);
`ifdef I2S_RX_PAIR_EN
            chk("pair_valid", pair_valid, e.pair);
            if (e.pair) begin
              chk("pair_left", pair_left, e.pl);
              chk("pair_right", pair_right, e.pr);
            end
`endif
          end
        end
      end
`ifdef I2S_RX_PAIR_EN
      if (pair_valid) chk("pair_orphan", {31'd0, pair_valid & ~rx_valid}, 0);
`endif
    end
  end

  logic [15:0] vals [4];
  int          len;
  int          r;

  initial begin
    vals[0] = 16'h0000;
    vals[1] = 16'hFFFF;
    vals[2] = 16'h8001;
    vals[3] = 16'h1234;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_data", rx_data, 0);
    chk("reset_right", rx_right, 0);
    chk("reset_valid", rx_valid, 0);
    chk("reset_err", rx_err, 0);
    #1 RST_n = 1'b1;
    @(posedge CLK);
    #1;

    for (int k = 0; k < 6; k++) send_slot(16'hA55A, 24, -1);
    for (int k = 0; k < 4; k++) send_slot(vals[k], 24, -1);

    send_slot(16'hC3C3, 24, -1);
    send_slot(16'h0F0F, 10, -1);
    send_slot(16'h5AA5, 24, -1);
    send_slot(16'hBEEF, 40, -1);
    send_slot(16'hCAFE, 24, -1);

    send_slot(16'h1357, 17, -1);
    send_slot(16'h2468, 16, -1);
    send_slot(16'h9ABC, 33, -1);
    send_slot(16'hDEF0, 34, -1);
    send_slot(16'h7777, 24, -1);

    send_slot(16'h4242, 24, 7);
    for (int k = 0; k < 4; k++) send_slot(16'h6000 + 16'(k), 24, -1);

    if (last_ch == 1'b0) send_slot(16'h0101, 24, -1);
    send_slot(16'h1111, 24, -1);
    send_slot(16'h2222, 24, -1);
    send_slot(16'h3333, 24, -1);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       len = 24;
      else if (r == 6) len = $urandom_range(17, 33);
      else if (r == 7) len = $urandom_range(2, 16);
      else if (r == 8) len = $urandom_range(34, 45);
      else             len = (($urandom & 1) != 0) ? 17 : 33;
      send_slot(16'($urandom), len, -1);
    end

    send_slot(16'hFACE, 24, -1);
    for (int k = 0; k < 100 && q.size() > 0; k++) @(posedge CLK);
    repeat (4) @(posedge CLK);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
